msched_gen: RTL

MSCHED_GEN -- requirements
Module: msched_gen

---
 rtl/msched_pkg.sv | 30 +++
 rtl/msched_sigma.sv | 27 ++
 rtl/msched_gen.sv | 74 +++++++
 3 files changed

// File: rtl/msched_pkg.sv
// Shared definitions for the SHA-2 message schedule generator: FSM encoding,
// round count per word width, and the sigma rotation/shift amounts.
package msched_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  function automatic int unsigned rounds_for(input int unsigned w);
    return (w == 64) ? 80 : 64;
  endfunction

  // SHA-256 small sigmas
  localparam int unsigned S0_ROT_A_32 = 7;
  localparam int unsigned S0_ROT_B_32 = 18;
  localparam int unsigned S0_SHR_32   = 3;
  localparam int unsigned S1_ROT_A_32 = 17;
  localparam int unsigned S1_ROT_B_32 = 19;
  localparam int unsigned S1_SHR_32   = 10;

  // SHA-512 small sigmas
  localparam int unsigned S0_ROT_A_64 = 1;
  localparam int unsigned S0_ROT_B_64 = 8;
  localparam int unsigned S0_SHR_64   = 7;
  localparam int unsigned S1_ROT_A_64 = 19;
  localparam int unsigned S1_ROT_B_64 = 61;
  localparam int unsigned S1_SHR_64   = 6;

endpackage

// File: rtl/msched_sigma.sv
// Combinational small-sigma functions s0/s1 for SHA-256 (W=32) or SHA-512 (W=64).
module msched_sigma
  import msched_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  output logic [W-1:0] s0,
  output logic [W-1:0] s1
);

  localparam int unsigned S0A = (W == 64) ? S0_ROT_A_64 : S0_ROT_A_32;
  localparam int unsigned S0B = (W == 64) ? S0_ROT_B_64 : S0_ROT_B_32;
  localparam int unsigned S0S = (W == 64) ? S0_SHR_64   : S0_SHR_32;
  localparam int unsigned S1A = (W == 64) ? S1_ROT_A_64 : S1_ROT_A_32;
  localparam int unsigned S1B = (W == 64) ? S1_ROT_B_64 : S1_ROT_B_32;
  localparam int unsigned S1S = (W == 64) ? S1_SHR_64   : S1_SHR_32;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W - n));
  endfunction

  assign s0 = rotr(x0, S0A) ^ rotr(x0, S0B) ^ (x0 >> S0S);
  assign s1 = rotr(x1, S1A) ^ rotr(x1, S1B) ^ (x1 >> S1S);

endmodule

// File: rtl/msched_gen.sv
// SHA-2 message schedule generator: streams W_0..W_{ROUNDS-1} from a 16-word
// shift-register window with valid/ready handshakes on both sides.
module msched_gen
  import msched_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [16*W-1:0] blk,
  input  logic            blk_valid,
  output logic            blk_ready,
  input  logic            abort,
  output logic [W-1:0]    wt,
  output logic [6:0]      wt_idx,
  output logic            wt_last,
  output logic            wt_valid,
  input  logic            wt_ready
);

  localparam int unsigned ROUNDS  = rounds_for(W);
  localparam logic [6:0]  LastIdx = 7'(ROUNDS - 1);

  state_e         state_q;
  logic [W-1:0]   m_q [16];
  logic [6:0]     idx_q;
  logic [W-1:0]   s0, s1, m_new;
  logic           xfer, load;

  assign wt       = m_q[0];
  assign wt_idx   = idx_q;
  assign wt_valid = (state_q == StRun);
  assign wt_last  = wt_valid && (idx_q == LastIdx);

  // abort suppresses the transfer, which also keeps blk_ready low on a final word
  assign xfer      = wt_valid & wt_ready & ~abort;
  assign blk_ready = (state_q == StIdle) | (xfer & wt_last);
  assign load      = blk_valid & blk_ready;

  msched_sigma #(
    .W(W)
  ) u_sigma (
    .x0(m_q[1]),
    .x1(m_q[14]),
    .s0(s0),
    .s1(s1)
  );

  assign m_new = m_q[0] + s0 + m_q[9] + s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      for (int k = 0; k < 16; k++) m_q[k] <= '0;
    end else if (load) begin
      state_q <= StRun;
      idx_q   <= '0;
      for (int k = 0; k < 16; k++) m_q[k] <= blk[(15-k)*W +: W];
    end else if (wt_valid && abort) begin
      state_q <= StIdle;
    end else if (xfer) begin
      for (int k = 0; k < 15; k++) m_q[k] <= m_q[k+1];
      m_q[15] <= m_new;
      if (wt_last) begin
        state_q <= StIdle;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + 7'd1;
      end
    end
  end

endmodule
